uart_cmd_assembler: RTL and testbench

- Sits directly downstream of the UART receiver.
- Consumes its one-cycle byte strobe and byte bus, and assembles two-byte request frames: byte 0 is the command, byte 1 is the sensor address.
- Validates each frame and presents it to the sensor-control logic over a valid/ready handshake.
- Aborts half-received frames after an inter-byte timeout and flags invalid or dropped bytes.

---
 rtl/uart_cmd_assembler.sv | 132 +++++++++++++
 tb/tb_uart_cmd_assembler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - assembles two-byte (command, address) frames from UART bytes
// and hands validated frames to the sensor-control logic over a valid/ready handshake.
module uart_cmd_assembler #(
  parameter int unsigned CLKS_TIMEOUT = 2500000,
  parameter logic [7:0]  MAX_CMD      = 8'h07,
  parameter logic [7:0]  MAX_ADDR     = 8'h1F
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Cmd_Ready,
  output logic       o_Cmd_Valid,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Addr,
  output logic       o_Timeout,
  output logic       o_Frame_Err,
  output logic       o_Overrun
);

  typedef enum logic [1:0] {
    S_WAIT_CMD  = 2'd0,
    S_WAIT_ADDR = 2'd1,
    S_CHECK     = 2'd2,
    S_HOLD      = 2'd3
  } state_t;

  localparam logic [21:0] TIMER_LAST = 22'(CLKS_TIMEOUT - 1);

  state_t      state, state_n;
  logic [21:0] timer, timer_n;
  logic [7:0]  cmd_reg, cmd_reg_n;
  logic [7:0]  addr_reg, addr_reg_n;
  logic [7:0]  cmd_out_n, addr_out_n;
  logic        valid_n, timeout_n, frame_err_n, overrun_n;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state       <= S_WAIT_CMD;
      timer       <= '0;
      cmd_reg     <= '0;
      addr_reg    <= '0;
      o_Cmd       <= '0;
      o_Addr      <= '0;
      o_Cmd_Valid <= 1'b0;
      o_Timeout   <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Overrun   <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      cmd_reg     <= cmd_reg_n;
      addr_reg    <= addr_reg_n;
      o_Cmd       <= cmd_out_n;
      o_Addr      <= addr_out_n;
      o_Cmd_Valid <= valid_n;
      o_Timeout   <= timeout_n;
      o_Frame_Err <= frame_err_n;
      o_Overrun   <= overrun_n;
    end
  end

  // Timer defaults to zero so it clears on every state entry and only runs in S_WAIT_ADDR.
  always_comb begin
    state_n     = state;
    timer_n     = '0;
    cmd_reg_n   = cmd_reg;
    addr_reg_n  = addr_reg;
    cmd_out_n   = o_Cmd;
    addr_out_n  = o_Addr;
    valid_n     = o_Cmd_Valid;
    timeout_n   = 1'b0;
    frame_err_n = 1'b0;
    overrun_n   = 1'b0;

    case (state)
      S_WAIT_CMD: begin
        if (i_Rx_DV) begin
          cmd_reg_n = i_Rx_Byte;
          state_n   = S_WAIT_ADDR;
        end
      end

      S_WAIT_ADDR: begin
        if (i_Rx_DV) begin
          addr_reg_n = i_Rx_Byte;
          state_n    = S_CHECK;
        end else if (timer == TIMER_LAST) begin
          timeout_n = 1'b1;
          state_n   = S_WAIT_CMD;
        end else begin
          timer_n = timer + 22'd1;
        end
      end

      S_CHECK: begin
        overrun_n = i_Rx_DV;
        if ((cmd_reg <= MAX_CMD) && (addr_reg <= MAX_ADDR)) begin
          cmd_out_n  = cmd_reg;
          addr_out_n = addr_reg;
          valid_n    = 1'b1;
          state_n    = S_HOLD;
        end else begin
          frame_err_n = 1'b1;
          state_n     = S_WAIT_CMD;
        end
      end

      S_HOLD: begin
        valid_n = 1'b1;
        if (i_Cmd_Ready) begin
          valid_n = 1'b0;
          // A byte arriving with the handshake starts the next frame immediately.
          if (i_Rx_DV) begin
            cmd_reg_n = i_Rx_Byte;
            state_n   = S_WAIT_ADDR;
          end else begin
            state_n = S_WAIT_CMD;
          end
        end else begin
          overrun_n = i_Rx_DV;
        end
      end

      default: begin
        state_n = S_WAIT_CMD;
        valid_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - directed and randomized self-checking bench for uart_cmd_assembler.
module tb_uart_cmd_assembler;

  localparam int unsigned TO       = 100;
  localparam int unsigned MAX_CMD  = 7;
  localparam int unsigned MAX_ADDR = 31;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'h00;
  logic       i_Cmd_Ready = 1'b0;
  logic       o_Cmd_Valid;
  logic [7:0] o_Cmd;
  logic [7:0] o_Addr;
  logic       o_Timeout;
  logic       o_Frame_Err;
  logic       o_Overrun;

  int passes = 0;
  int total  = 0;
  int n_to = 0, n_fe = 0, n_ov = 0;
  int exp_to = 0, exp_fe = 0, exp_ov = 0;
  logic [7:0] last_cmd = 8'h00, last_addr = 8'h00;

  uart_cmd_assembler #(
    .CLKS_TIMEOUT(TO),
    .MAX_CMD     (8'h07),
    .MAX_ADDR    (8'h1F)
  ) dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Rx_DV    (i_Rx_DV),
    .i_Rx_Byte  (i_Rx_Byte),
    .i_Cmd_Ready(i_Cmd_Ready),
    .o_Cmd_Valid(o_Cmd_Valid),
    .o_Cmd      (o_Cmd),
    .o_Addr     (o_Addr),
    .o_Timeout  (o_Timeout),
    .o_Frame_Err(o_Frame_Err),
    .o_Overrun  (o_Overrun)
  );

  always #5 i_Clock = ~i_Clock;

  // Event counters sampled on the falling edge, away from the active edge.
  always @(negedge i_Clock) begin
    if (o_Timeout)   n_to++;
    if (o_Frame_Err) n_fe++;
    if (o_Overrun)   n_ov++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    step();
    i_Rx_DV   = 1'b0;
  endtask

  function automatic bit legal(input logic [7:0] c, input logic [7:0] a);
    return (int'(c) <= MAX_CMD) && (int'(a) <= MAX_ADDR);
  endfunction

  task automatic check_counts(input string tag);
    check({tag, "_timeouts"}, n_to, exp_to);
    check({tag, "_frame_errs"}, n_fe, exp_fe);
    check({tag, "_overruns"}, n_ov, exp_ov);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] c, input logic [7:0] a);
    check({tag, "_valid"}, o_Cmd_Valid, 1);
    check({tag, "_cmd"}, o_Cmd, c);
    check({tag, "_addr"}, o_Addr, a);
  endtask

  task automatic release_frame();
    i_Cmd_Ready = 1'b1;
    step();
    i_Cmd_Ready = 1'b0;
  endtask

  initial begin
    logic [7:0] c, a, b;
    int gap, hold;

    // Reset state
    repeat (3) step();
    check("rst_valid", o_Cmd_Valid, 0);
    check("rst_cmd", o_Cmd, 0);
    check("rst_addr", o_Addr, 0);
    check("rst_pulses", {o_Timeout, o_Frame_Err, o_Overrun}, 0);
    i_Reset = 1'b0;
    step();

    // Valid frame with two-cycle latency
    send_byte(8'h03);
    repeat (50) step();
    send_byte(8'h05);
    check("lat_not_yet", o_Cmd_Valid, 0);
    step();
    check_frame("valid1", 8'h03, 8'h05);
    i_Cmd_Ready = 1'b1;
    step();
    i_Cmd_Ready = 1'b0;
    check("valid1_fall", o_Cmd_Valid, 0);
    last_cmd = 8'h03; last_addr = 8'h05;
    step();
    check_counts("valid1");

    // Backpressure and overrun
    send_byte(8'h01);
    send_byte(8'h02);
    step();
    repeat (1000) step();
    check_frame("bp_hold", 8'h01, 8'h02);
    send_byte(8'hAA);
    exp_ov++;
    check("bp_ov_pulse", o_Overrun, 1);
    step();
    check("bp_ov_single", o_Overrun, 0);
    check_frame("bp_kept", 8'h01, 8'h02);
    release_frame();
    check("bp_released", o_Cmd_Valid, 0);
    send_byte(8'h06);
    send_byte(8'h07);
    step();
    check_frame("bp_next", 8'h06, 8'h07);
    release_frame();
    last_cmd = 8'h06; last_addr = 8'h07;
    check_counts("bp");

    // Timeout
    send_byte(8'h02);
    repeat (TO - 1) step();
    check("to_early", o_Timeout, 0);
    step();
    exp_to++;
    check("to_pulse", o_Timeout, 1);
    step();
    check("to_single", o_Timeout, 0);
    send_byte(8'h04);
    send_byte(8'h06);
    step();
    check_frame("to_fresh", 8'h04, 8'h06);
    release_frame();
    last_cmd = 8'h04; last_addr = 8'h06;
    check_counts("to");

    // Frame errors and boundary
    send_byte(8'h08);
    send_byte(8'h00);
    step();
    exp_fe++;
    check("fe1_pulse", o_Frame_Err, 1);
    check("fe1_novalid", o_Cmd_Valid, 0);
    check("fe1_cmd_kept", o_Cmd, last_cmd);
    send_byte(8'h00);
    check("fe1_single", o_Frame_Err, 0);
    send_byte(8'h20);
    step();
    exp_fe++;
    check("fe2_pulse", o_Frame_Err, 1);
    check("fe2_novalid", o_Cmd_Valid, 0);
    check("fe2_addr_kept", o_Addr, last_addr);
    send_byte(8'h07);
    send_byte(8'h1F);
    step();
    check_frame("boundary", 8'h07, 8'h1F);
    release_frame();
    last_cmd = 8'h07; last_addr = 8'h1F;
    check_counts("fe");

    // Address byte on the exact timeout cycle wins
    send_byte(8'h05);
    repeat (TO - 1) step();
    send_byte(8'h09);
    check("coinc_no_to", o_Timeout, 0);
    step();
    check_frame("coinc_to", 8'h05, 8'h09);
    // Byte with ready becomes the next command
    i_Cmd_Ready = 1'b1;
    send_byte(8'h02);
    i_Cmd_Ready = 1'b0;
    check("coinc_rdy_fall", o_Cmd_Valid, 0);
    check("coinc_rdy_no_ov", o_Overrun, 0);
    send_byte(8'h03);
    step();
    check_frame("coinc_rdy", 8'h02, 8'h03);
    release_frame();
    last_cmd = 8'h02; last_addr = 8'h03;
    check_counts("coinc");

    // Reset in S_WAIT_ADDR and in S_HOLD
    send_byte(8'h01);
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    check("rst1_outs", {o_Cmd_Valid, o_Cmd, o_Addr, o_Timeout, o_Frame_Err, o_Overrun}, 0);
    send_byte(8'h04);
    send_byte(8'h04);
    step();
    check_frame("rst2_pre", 8'h04, 8'h04);
    i_Reset = 1'b1;
    step();
    i_Reset = 1'b0;
    check("rst2_outs", {o_Cmd_Valid, o_Cmd, o_Addr, o_Timeout, o_Frame_Err, o_Overrun}, 0);
    last_cmd = 8'h00; last_addr = 8'h00;
    repeat (TO + 5) step();
    send_byte(8'h05);
    send_byte(8'h01);
    step();
    check_frame("rst_after", 8'h05, 8'h01);
    release_frame();
    last_cmd = 8'h05; last_addr = 8'h01;
    check_counts("rst");

    // Randomized frames against the transaction-level model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        c = 8'($urandom);
        send_byte(c);
        repeat (TO + 1) step();
        exp_to++;
        check("rnd_to_novalid", o_Cmd_Valid, 0);
      end else begin
        c = 8'($urandom_range(0, 15));
        a = 8'($urandom_range(0, 47));
        gap = $urandom_range(0, TO - 1);
        send_byte(c);
        repeat (gap) step();
        send_byte(a);
        step();
        if (legal(c, a)) begin
          check_frame("rnd_frame", c, a);
          hold = $urandom_range(0, 4);
          for (int h = 0; h < hold; h++) begin
            if ($urandom_range(0, 1) == 1) begin
              b = 8'($urandom);
              send_byte(b);
              exp_ov++;
            end else begin
              step();
            end
          end
          check_frame("rnd_held", c, a);
          release_frame();
          check("rnd_released", o_Cmd_Valid, 0);
          last_cmd = c; last_addr = a;
        end else begin
          exp_fe++;
          check("rnd_fe_novalid", o_Cmd_Valid, 0);
          check("rnd_fe_cmd_kept", o_Cmd, last_cmd);
          check("rnd_fe_addr_kept", o_Addr, last_addr);
        end
      end
      step();
      check_counts("rnd");
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
